// File: rtl/uart_alu_interface_pkg.sv
// Shared definitions for the UART <-> ALU glue block:
// default data/opcode widths and the 3-bit FSM state encodings.
package uart_alu_interface_pkg;

    localparam int D_BIT_DEF  = 8;
    localparam int OP_BIT_DEF = 6;

    localparam logic [2:0] GET_A   = 3'd0;
    localparam logic [2:0] GET_B   = 3'd1;
    localparam logic [2:0] GET_OP  = 3'd2;
    localparam logic [2:0] RESULT  = 3'd3;
    localparam logic [2:0] SEND    = 3'd4;
    localparam logic [2:0] WAIT_TX = 3'd5;

endpackage

// File: rtl/uart_alu_interface.sv
// uart_alu_interface: gathers operand A, operand B and opcode bytes from the
// UART receiver, drives them to an external combinational ALU, captures the
// result and hands it to the UART transmitter with a start/done handshake.
// Optional feature macro: INTF_TIMEOUT_EN (inter-byte timeout abort).
module uart_alu_interface
    import uart_alu_interface_pkg::*;
#(
    parameter int D_BIT       = D_BIT_DEF,
    parameter int OP_BIT      = OP_BIT_DEF,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_rx_done_tick,
    input  logic [D_BIT-1:0]  i_rx_data,
    input  logic [D_BIT-1:0]  i_alu_result,
    input  logic              i_tx_done_tick,
    output logic [D_BIT-1:0]  o_alu_a,
    output logic [D_BIT-1:0]  o_alu_b,
    output logic [OP_BIT-1:0] o_alu_op,
    output logic [D_BIT-1:0]  o_tx_data,
    output logic              o_tx_start,
    output logic              o_busy,
    output logic              o_overrun,
    output logic              o_timeout
);

    logic [2:0] state;
    logic [2:0] state_next;
    logic       to_hit;     // frame abort this cycle (timeout build only)
    logic       byte_take;  // received byte is usable this cycle

    // A byte landing on the abort cycle is discarded with the frame.
    assign byte_take = i_rx_done_tick && !to_hit;

`ifdef INTF_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] to_cnt;

    assign to_hit = ((state == GET_B) || (state == GET_OP)) && (to_cnt == TO_LAST);

    // Inter-byte counter: runs only while mid-frame, restarts on every byte.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            to_cnt <= '0;
        else if (byte_take || to_hit || !((state == GET_B) || (state == GET_OP)))
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + TO_W'(1);
    end
`else
    // Constant false: no abort path exists in this build.
    assign to_hit = (TIMEOUT_CYC < 0);
`endif

    // Next-state decode; timeout abort overrides the normal transition.
    always_comb begin
        state_next = state;
        case (state)
            GET_A:   if (byte_take)      state_next = GET_B;
            GET_B:   if (byte_take)      state_next = GET_OP;
            GET_OP:  if (byte_take)      state_next = RESULT;
            RESULT:                      state_next = SEND;
            SEND:                        state_next = WAIT_TX;
            WAIT_TX: if (i_tx_done_tick) state_next = GET_A;
            default:                     state_next = GET_A;
        endcase
        if (to_hit)
            state_next = GET_A;
    end

    // State, operand/result capture and registered status pulses.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= GET_A;
            o_alu_a    <= '0;
            o_alu_b    <= '0;
            o_alu_op   <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_busy     <= 1'b0;
            o_overrun  <= 1'b0;
            o_timeout  <= 1'b0;
        end else begin
            state <= state_next;
            if ((state == GET_A) && byte_take)
                o_alu_a <= i_rx_data;
            if ((state == GET_B) && byte_take)
                o_alu_b <= i_rx_data;
            if ((state == GET_OP) && byte_take)
                o_alu_op <= i_rx_data[OP_BIT-1:0];
            // Operands were registered last cycle, so the ALU has settled.
            if (state == RESULT)
                o_tx_data <= i_alu_result;
            o_tx_start <= (state_next == SEND);
            o_busy     <= (state_next != GET_A);
            o_overrun  <= i_rx_done_tick && ((state == SEND) || (state == WAIT_TX));
            o_timeout  <= to_hit;
        end
    end

endmodule
